// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: shared AXI4-Lite types and constants.
//   axi_mst_state_e   master bridge FSM states
//   AXI_RESP_*        B/R response codes
//   AXI_PROT_DEFAULT  protection attribute driven on AW/AR
//   axi_resp_is_err() true for SLVERR and DECERR
package axi_lite_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WRESP,
    READ,
    RDATA
  } axi_mst_state_e;

  typedef logic [1:0] axi_resp_t;

  localparam axi_resp_t AXI_RESP_OKAY   = 2'b00;
  localparam axi_resp_t AXI_RESP_EXOKAY = 2'b01;
  localparam axi_resp_t AXI_RESP_SLVERR = 2'b10;
  localparam axi_resp_t AXI_RESP_DECERR = 2'b11;

  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

  function automatic logic axi_resp_is_err(input axi_resp_t resp);
    return (resp == AXI_RESP_SLVERR) || (resp == AXI_RESP_DECERR);
  endfunction

endpackage

// File: rtl/axi_lite_master_bridge_if.sv
// AXI_BUS: AXI4-Lite channel bundle (AW/W/B/AR/R).
//   Master modport: drives addresses, write data, valids on AW/W/AR and
//                   readies on B/R.
//   Slave modport:  the mirror image.
// Parameters: ADDR_WIDTH, DATA_WIDTH (strobe width is DATA_WIDTH/8).
interface AXI_BUS #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [2:0]            aw_prot;
  logic                  aw_valid;
  logic                  aw_ready;

  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_WIDTH-1:0] w_strb;
  logic                  w_valid;
  logic                  w_ready;

  logic [1:0]            b_resp;
  logic                  b_valid;
  logic                  b_ready;

  logic [ADDR_WIDTH-1:0] ar_addr;
  logic [2:0]            ar_prot;
  logic                  ar_valid;
  logic                  ar_ready;

  logic [DATA_WIDTH-1:0] r_data;
  logic [1:0]            r_resp;
  logic                  r_valid;
  logic                  r_ready;

  modport Master (
    output aw_addr, aw_prot, aw_valid, input aw_ready,
    output w_data, w_strb, w_valid,    input w_ready,
    input  b_resp, b_valid,            output b_ready,
    output ar_addr, ar_prot, ar_valid, input ar_ready,
    input  r_data, r_resp, r_valid,    output r_ready
  );

  modport Slave (
    input  aw_addr, aw_prot, aw_valid, output aw_ready,
    input  w_data, w_strb, w_valid,    output w_ready,
    output b_resp, b_valid,            input b_ready,
    input  ar_addr, ar_prot, ar_valid, output ar_ready,
    output r_data, r_resp, r_valid,    input r_ready
  );

endinterface

// File: rtl/axi_lite_master_bridge.sv
// axi_lite_master_bridge: single-outstanding AXI4-Lite master that turns a
// req/gnt/rvalid core data interface into AXI-Lite reads and writes.
//   clk, rst            clock, asynchronous active-high reset
//   req_i/we_i/addr_i/wdata_i/be_i   request (held until gnt_o)
//   gnt_o               request accepted (combinational, IDLE only)
//   rvalid_o/rdata_o/err_o           one-cycle completion with read data / error
//   axi_master          AXI_BUS.Master
// Optional macro AXI_MASTER_TIMEOUT_EN adds a response watchdog that aborts a
// transaction after TIMEOUT_CYCLES busy cycles and completes it with err_o = 1.
module axi_lite_master_bridge
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_i,
  input  logic                    we_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  output logic                    gnt_o,
  output logic                    rvalid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    err_o,
  AXI_BUS.Master                  axi_master
);

  localparam int BE_W = DATA_WIDTH / 8;

  axi_mst_state_e        state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]       be_q, be_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic                  rvalid_q, rvalid_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic aw_valid, w_valid, b_ready, ar_valid, r_ready;
  logic tmo_hit;

`ifdef AXI_MASTER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             done_now;

  // A response arriving on the last allowed cycle wins over the abort.
  assign done_now  = ((state_q == WRESP) && axi_master.b_valid) ||
                     ((state_q == RDATA) && axi_master.r_valid);
  assign tmo_hit   = (state_q != IDLE) && !done_now &&
                     (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
  assign tmo_cnt_d = ((state_q == IDLE) || done_now || tmo_hit) ? '0
                                                                : tmo_cnt_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmo_cnt_q <= '0;
    else     tmo_cnt_q <= tmo_cnt_d;
  end
`else
  logic [31:0] unused_timeout_cycles;

  assign tmo_hit               = 1'b0;
  assign unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rvalid_d  = 1'b0;
    err_d     = err_q;
    rdata_d   = rdata_q;
    gnt_o     = 1'b0;
    aw_valid  = 1'b0;
    w_valid   = 1'b0;
    b_ready   = 1'b0;
    ar_valid  = 1'b0;
    r_ready   = 1'b0;

    unique case (state_q)
      IDLE: begin
        gnt_o = req_i;
        if (req_i) begin
          addr_d    = addr_i;
          wdata_d   = wdata_i;
          be_d      = be_i;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = we_i ? WRITE : READ;
        end
      end
      WRITE: begin
        // AW and W complete independently; each valid drops once its own
        // handshake has been recorded.
        aw_valid  = !aw_done_q;
        w_valid   = !w_done_q;
        aw_done_d = aw_done_q || axi_master.aw_ready;
        w_done_d  = w_done_q  || axi_master.w_ready;
        if (aw_done_d && w_done_d) state_d = WRESP;
      end
      WRESP: begin
        b_ready = 1'b1;
        if (axi_master.b_valid) begin
          rvalid_d = 1'b1;
          err_d    = axi_resp_is_err(axi_master.b_resp);
          state_d  = IDLE;
        end
      end
      READ: begin
        ar_valid = 1'b1;
        if (axi_master.ar_ready) state_d = RDATA;
      end
      RDATA: begin
        r_ready = 1'b1;
        if (axi_master.r_valid) begin
          rvalid_d = 1'b1;
          rdata_d  = axi_master.r_data;
          err_d    = axi_resp_is_err(axi_master.r_resp);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Watchdog abort: valids/readies are pulled low in the abort cycle itself
    // so no handshake can slip through that the FSM would then forget.
    if (tmo_hit) begin
      aw_valid  = 1'b0;
      w_valid   = 1'b0;
      b_ready   = 1'b0;
      ar_valid  = 1'b0;
      r_ready   = 1'b0;
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
      rvalid_d  = 1'b1;
      err_d     = 1'b1;
      rdata_d   = rdata_q;
      state_d   = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;

  assign axi_master.aw_addr  = addr_q;
  assign axi_master.aw_prot  = AXI_PROT_DEFAULT;
  assign axi_master.aw_valid = aw_valid;
  assign axi_master.w_data   = wdata_q;
  assign axi_master.w_strb   = be_q;
  assign axi_master.w_valid  = w_valid;
  assign axi_master.b_ready  = b_ready;
  assign axi_master.ar_addr  = addr_q;
  assign axi_master.ar_prot  = AXI_PROT_DEFAULT;
  assign axi_master.ar_valid = ar_valid;
  assign axi_master.r_ready  = r_ready;

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// Directed bench for axi_lite_master_bridge. The bench plays the AXI slave by
// hand; inputs change on the falling edge and outputs are sampled 1 ns later.
module tb_axi_lite_master_bridge;
  import axi_lite_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_i, we_i;
  logic [31:0] addr_i, wdata_i;
  logic [3:0]  be_i;
  logic        gnt_o, rvalid_o, err_o;
  logic [31:0] rdata_o;

  int n_cmp = 0;
  int n_bad = 0;

  AXI_BUS #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axi_lite_master_bridge #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .err_o(err_o), .axi_master(bus)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    @(negedge clk); #1;
    n_cmp++; if ({bus.aw_valid, bus.w_valid, bus.b_ready, bus.ar_valid, bus.r_ready} !== 5'b0) begin
      n_bad++; $display("FAIL reset_valids: got %b expected 00000",
        {bus.aw_valid, bus.w_valid, bus.b_ready, bus.ar_valid, bus.r_ready}); end
    n_cmp++; if ({rvalid_o, err_o} !== 2'b00) begin
      n_bad++; $display("FAIL reset_rvalid_err: got %b expected 00", {rvalid_o, err_o}); end
    n_cmp++; if (rdata_o !== 32'h0) begin
      n_bad++; $display("FAIL reset_rdata: got %h expected 00000000", rdata_o); end
    @(negedge clk); rst = 1'b0; #1;
    n_cmp++; if (gnt_o !== 1'b0) begin
      n_bad++; $display("FAIL reset_gnt_idle: got %b expected 0", gnt_o); end
  endtask

  task automatic test_write_zero_wait();
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h0000_0004; wdata_i = 32'hDEAD_BEEF; be_i = 4'hF;
    bus.aw_ready = 1'b1; bus.w_ready = 1'b1; bus.b_valid = 1'b0; bus.b_resp = AXI_RESP_OKAY;
    #1;
    n_cmp++; if (gnt_o !== 1'b1) begin n_bad++; $display("FAIL wr_gnt: got %b expected 1", gnt_o); end
    @(negedge clk); req_i = 1'b0; addr_i = 32'h0; wdata_i = 32'h0; be_i = 4'h0; #1;  // T+1
    n_cmp++; if ({bus.aw_valid, bus.w_valid} !== 2'b11) begin
      n_bad++; $display("FAIL wr_valids_t1: got %b expected 11", {bus.aw_valid, bus.w_valid}); end
    n_cmp++; if (bus.aw_addr !== 32'h0000_0004 || bus.aw_prot !== 3'b000) begin
      n_bad++; $display("FAIL wr_aw_addr_prot: got %h/%b expected 00000004/000", bus.aw_addr, bus.aw_prot); end
    n_cmp++; if (bus.w_data !== 32'hDEAD_BEEF || bus.w_strb !== 4'hF) begin
      n_bad++; $display("FAIL wr_wdata_strb: got %h/%h expected deadbeef/f", bus.w_data, bus.w_strb); end
    @(negedge clk); bus.b_valid = 1'b1; #1;  // T+2
    n_cmp++; if ({bus.aw_valid, bus.w_valid, bus.b_ready} !== 3'b001) begin
      n_bad++; $display("FAIL wr_wresp_t2: got %b expected 001", {bus.aw_valid, bus.w_valid, bus.b_ready}); end
    @(negedge clk); bus.b_valid = 1'b0; #1;  // T+3
    n_cmp++; if ({rvalid_o, err_o, bus.b_ready} !== 3'b100) begin
      n_bad++; $display("FAIL wr_rvalid_t3: got %b expected 100", {rvalid_o, err_o, bus.b_ready}); end
    n_cmp++; if (rdata_o !== 32'h0) begin
      n_bad++; $display("FAIL wr_rdata_unchanged: got %h expected 00000000", rdata_o); end
    @(negedge clk); #1;
    n_cmp++; if (rvalid_o !== 1'b0) begin n_bad++; $display("FAIL wr_rvalid_pulse: got %b expected 0", rvalid_o); end
  endtask

  task automatic test_write_aw_delay();
    int awc = 0, wc = 0, bc = 0, rvc = 0;
    logic err_seen = 1'b0;
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h0000_0008; wdata_i = 32'h0102_0304; be_i = 4'h5;
    bus.aw_ready = 1'b0; bus.w_ready = 1'b1; bus.b_valid = 1'b0; bus.b_resp = AXI_RESP_OKAY;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      req_i = 1'b0;
      bus.aw_ready = (i >= 2);
      bus.b_valid  = (bc == 0);  // B offered early, accepted only once
      #1;
      if (bus.aw_valid) awc++;
      if (bus.w_valid) wc++;
      if (bus.b_valid && bus.b_ready) bc++;
      if (rvalid_o) begin rvc++; err_seen = err_o; end
    end
    bus.b_valid = 1'b0;
    n_cmp++; if (awc !== 3) begin n_bad++; $display("FAIL awdly_aw_cycles: got %0d expected 3", awc); end
    n_cmp++; if (wc !== 1) begin n_bad++; $display("FAIL awdly_w_cycles: got %0d expected 1", wc); end
    n_cmp++; if (bc !== 1) begin n_bad++; $display("FAIL awdly_b_accepts: got %0d expected 1", bc); end
    n_cmp++; if (rvc !== 1 || err_seen !== 1'b0) begin
      n_bad++; $display("FAIL awdly_rvalid: got %0d pulses err %b expected 1 pulse err 0", rvc, err_seen); end
  endtask

  task automatic test_read_wait();
    int rvc = 0, idx = -1;
    logic [31:0] rd = 32'h0;
    logic er = 1'b1;
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h0000_0010;
    bus.ar_ready = 1'b1; bus.r_valid = 1'b0; bus.r_resp = AXI_RESP_OKAY;
    #1;
    n_cmp++; if (gnt_o !== 1'b1) begin n_bad++; $display("FAIL rd_gnt: got %b expected 1", gnt_o); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      req_i = 1'b0;
      bus.r_valid = (i == 3);
      bus.r_data  = (i == 3) ? 32'h1234_5678 : 32'hFFFF_FFFF;
      #1;
      if (i == 0) begin
        n_cmp++; if (bus.ar_valid !== 1'b1 || bus.ar_addr !== 32'h0000_0010 || bus.ar_prot !== 3'b000) begin
          n_bad++; $display("FAIL rd_ar: got %b/%h/%b expected 1/00000010/000",
            bus.ar_valid, bus.ar_addr, bus.ar_prot); end
      end
      if (rvalid_o) begin rvc++; idx = i; rd = rdata_o; er = err_o; end
    end
    bus.r_valid = 1'b0;
    n_cmp++; if (rvc !== 1 || idx !== 4) begin
      n_bad++; $display("FAIL rd_rvalid_once: got %0d pulses at %0d expected 1 at 4", rvc, idx); end
    n_cmp++; if (rd !== 32'h1234_5678 || er !== 1'b0) begin
      n_bad++; $display("FAIL rd_data_err: got %h/%b expected 12345678/0", rd, er); end
    n_cmp++; if (rdata_o !== 32'h1234_5678) begin
      n_bad++; $display("FAIL rd_data_hold: got %h expected 12345678", rdata_o); end
  endtask

  task automatic test_decerr_back_to_back();
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h0000_0020;
    bus.ar_ready = 1'b1; bus.r_valid = 1'b0;
    @(negedge clk); req_i = 1'b0;  // T+1: early R, ignored while in READ
    bus.r_valid = 1'b1; bus.r_resp = AXI_RESP_DECERR; bus.r_data = 32'h0BAD_BAD0;
    @(negedge clk); #1;  // T+2
    n_cmp++; if (bus.r_ready !== 1'b1) begin n_bad++; $display("FAIL dec_rready: got %b expected 1", bus.r_ready); end
    @(negedge clk); bus.r_valid = 1'b0;  // T+3
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h0000_0030; wdata_i = 32'h55AA_55AA; be_i = 4'h3;
    bus.aw_ready = 1'b1; bus.w_ready = 1'b1; bus.b_valid = 1'b0; bus.b_resp = AXI_RESP_OKAY;
    #1;
    n_cmp++; if ({rvalid_o, err_o} !== 2'b11 || rdata_o !== 32'h0BAD_BAD0) begin
      n_bad++; $display("FAIL dec_err: got %b/%h expected 11/0badbad0", {rvalid_o, err_o}, rdata_o); end
    n_cmp++; if (gnt_o !== 1'b1) begin n_bad++; $display("FAIL dec_b2b_gnt: got %b expected 1", gnt_o); end
    @(negedge clk); req_i = 1'b0; bus.b_valid = 1'b1; #1;
    n_cmp++; if (bus.aw_addr !== 32'h0000_0030 || bus.w_strb !== 4'h3 || bus.w_data !== 32'h55AA_55AA) begin
      n_bad++; $display("FAIL b2b_wr_fields: got %h/%h/%h expected 00000030/3/55aa55aa",
        bus.aw_addr, bus.w_strb, bus.w_data); end
    @(negedge clk); #1;
    @(negedge clk); bus.b_valid = 1'b0; #1;
    n_cmp++; if ({rvalid_o, err_o} !== 2'b10 || rdata_o !== 32'h0BAD_BAD0) begin
      n_bad++; $display("FAIL b2b_wr_done: got %b/%h expected 10/0badbad0", {rvalid_o, err_o}, rdata_o); end
  endtask

  task automatic test_no_bresp();
    int rvc = 0, idx = -1;
    logic er = 1'b0;
    logic [31:0] rd = 32'h0;
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h0000_0040; wdata_i = 32'h1111_2222; be_i = 4'hF;
    bus.aw_ready = 1'b1; bus.w_ready = 1'b1; bus.b_valid = 1'b0;
`ifdef AXI_MASTER_TIMEOUT_EN
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); req_i = 1'b0; #1;
      if (rvalid_o) begin rvc++; idx = i; er = err_o; rd = rdata_o; end
    end
    n_cmp++; if (rvc !== 1 || idx !== 16) begin
      n_bad++; $display("FAIL tmo_rvalid: got %0d pulses at %0d expected 1 at 16", rvc, idx); end
    n_cmp++; if (er !== 1'b1 || rd !== 32'h0BAD_BAD0) begin
      n_bad++; $display("FAIL tmo_err_rdata: got %b/%h expected 1/0badbad0", er, rd); end
    n_cmp++; if (bus.b_ready !== 1'b0) begin n_bad++; $display("FAIL tmo_bready_low: got %b expected 0", bus.b_ready); end
`else
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); req_i = 1'b0; #1;
      if (rvalid_o) rvc++;
    end
    n_cmp++; if (rvc !== 0 || bus.b_ready !== 1'b1) begin
      n_bad++; $display("FAIL hang_wait: got %0d pulses b_ready %b expected 0 pulses b_ready 1", rvc, bus.b_ready); end
    bus.b_valid = 1'b1; bus.b_resp = AXI_RESP_SLVERR;
    @(negedge clk); bus.b_valid = 1'b0; #1;
    idx = 0; er = err_o; rd = rdata_o;
    n_cmp++; if ({rvalid_o, er} !== 2'b11 || rd !== 32'h0BAD_BAD0) begin
      n_bad++; $display("FAIL hang_slverr: got %b/%h expected 11/0badbad0", {rvalid_o, er}, rd); end
`endif
  endtask

  task automatic test_reset_mid();
    int rvc = 0;
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h0000_0050; wdata_i = 32'hA5A5_A5A5; be_i = 4'hF;
    bus.aw_ready = 1'b1; bus.w_ready = 1'b1; bus.b_valid = 1'b0; bus.b_resp = AXI_RESP_OKAY;
    @(negedge clk); req_i = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if (bus.b_ready !== 1'b1 || dut.state_q !== WRESP) begin
      n_bad++; $display("FAIL rstmid_in_wresp: got %b/%0d expected 1/%0d", bus.b_ready, dut.state_q, WRESP); end
    rst = 1'b1; #1;
    n_cmp++; if ({bus.aw_valid, bus.w_valid, bus.b_ready, bus.ar_valid, bus.r_ready, rvalid_o} !== 6'b0) begin
      n_bad++; $display("FAIL rstmid_async: got %b expected 000000",
        {bus.aw_valid, bus.w_valid, bus.b_ready, bus.ar_valid, bus.r_ready, rvalid_o}); end
    n_cmp++; if (rdata_o !== 32'h0) begin n_bad++; $display("FAIL rstmid_rdata: got %h expected 00000000", rdata_o); end
    @(negedge clk); rst = 1'b0; bus.b_valid = 1'b1;  // stray B must not be taken
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      if (rvalid_o) rvc++;
    end
    bus.b_valid = 1'b0;
    n_cmp++; if (rvc !== 0 || dut.state_q !== IDLE) begin
      n_bad++; $display("FAIL rstmid_idle: got %0d pulses state %0d expected 0 pulses state %0d", rvc, dut.state_q, IDLE); end
  endtask

  initial begin
    rst = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0; be_i = '0;
    bus.aw_ready = 1'b0; bus.w_ready = 1'b0; bus.b_valid = 1'b0; bus.b_resp = 2'b00;
    bus.ar_ready = 1'b0; bus.r_valid = 1'b0; bus.r_resp = 2'b00; bus.r_data = '0;
    test_reset();
    test_write_zero_wait();
    test_write_aw_delay();
    test_read_wait();
    test_decerr_back_to_back();
    test_no_bresp();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
